mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-client arbiter between the instruction cache and data cache memory-side ports and the single main-memory port.
- Serialises one memory transaction at a time: address handshake, write-data beats or read-response beats.
- Routes read responses back to the owning cache.
- Pure routing/control; no data buffering beyond the owner/state/beat registers.

Parameters:
- MEM_DATA_BITS, `MEM_DATA_BITS (128), memory beat width.
- MEM_ADDR_BITS, 28, memory beat address width (30-bit word address minus 2 word-offset bits).
- READ_BEATS, 4, response beats returned per read request.
- WRITE_BEATS, 1, data beats sent per write request.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- ic_req_valid / dc_req_valid  in  1  client request valid
- ic_req_ready / dc_req_ready  out  1  client request accepted
- ic_req_addr / dc_req_addr  in  MEM_ADDR_BITS  client beat address
- ic_req_rw / dc_req_rw  in  1  1=write, 0=read
- ic_req_data_valid / dc_req_data_valid  in  1  client write beat valid
- ic_req_data_ready / dc_req_data_ready  out  1  client write beat accepted
- ic_req_data_bits / dc_req_data_bits  in  MEM_DATA_BITS  write data
- ic_req_data_mask / dc_req_data_mask  in  MEM_DATA_BITS/8  byte mask
- ic_resp_valid / dc_resp_valid  out  1  read beat to client
- ic_resp_data / dc_resp_data  out  MEM_DATA_BITS  read data (copy of mem_resp_data)
- mem_req_valid  out  1
- mem_req_ready  in  1
- mem_req_addr  out  MEM_ADDR_BITS
- mem_req_rw  out  1
- mem_req_data_valid  out  1
- mem_req_data_ready  in  1
- mem_req_data_bits  out  MEM_DATA_BITS
- mem_req_data_mask  out  MEM_DATA_BITS/8
- mem_resp_valid  in  1
- mem_resp_data  in  MEM_DATA_BITS
- err_stray_resp  out  1  sticky: mem_resp_valid seen outside RRESP

Behaviour:
- Reset: state IDLE, owner=none, last_grant=IC (so DC wins first tie), beat counter 0, err_stray_resp 0.
  - All valid/ready outputs 0 while reset is high and in the following IDLE cycle unless a request is present.
  - Reset mid-transaction aborts it; no response is routed afterwards.
- States:
  - IDLE: choose winner among valid requests.
    - Single requester wins.
    - Both requesting: winner = client not equal to last_grant (round-robin).
    - Winner is latched as owner; last_grant <= winner; go to REQ the next cycle. No output handshake in IDLE.
  - REQ: mem_req_valid/addr/rw driven combinationally from owner's inputs.
    - owner req_ready = mem_req_ready; other client req_ready=0.
    - On mem_req_valid && mem_req_ready: rw=1 -> WDATA; rw=0 -> RRESP. Beat counter cleared.
    - If owner drops req_valid before handshake: return to IDLE.
  - WDATA: mem_req_data_valid/bits/mask pass through from owner.
    - owner data_ready = mem_req_data_ready.
    - Each data handshake increments counter; after WRITE_BEATS beats -> IDLE.
  - RRESP: owner resp_valid = mem_resp_valid; non-owner resp_valid=0.
    - Each mem_resp_valid increments counter; on the READ_BEATS-th beat -> IDLE in the same cycle edge.
    - Responses cannot be stalled (no resp_ready).
- Both ic_resp_data and dc_resp_data always equal mem_resp_data; only valid is steered.
- mem_resp_valid in IDLE/REQ/WDATA: beat dropped, err_stray_resp set until reset.
- Minimum latency: request valid at cycle 0 -> mem_req_valid at cycle 1. Back-to-back transactions have one IDLE cycle between them.
- Counter width ceilLog2(max(READ_BEATS,WRITE_BEATS))+1; no wrap within a transaction.

Decomposition:
- Shared header (const.vh / util.vh): MEM_DATA_BITS, ceilLog2, state encodings ARB_IDLE/ARB_REQ/ARB_WDATA/ARB_RRESP, client IDs ARB_IC=0/ARB_DC=1.
- One sub-module natural: arb_rr2 (2-input round-robin picker with last_grant register).

Test Plan:
- IC read alone, addr 0x0000010 -> mem_req_addr 0x0000010 rw=0 at cycle 1; 4 mem_resp beats D0..D3 -> ic_resp_valid 4 cycles with D0..D3, dc_resp_valid stays 0.
- IC read and DC write asserted same cycle after reset -> DC granted first (write, mask 0x000F, data 0xDEADBEEF in lane 0 appears on mem port); IC served next; then a second tie grants DC.
- mem_req_ready held low 10 cycles in REQ -> ic/dc req_ready low, mem_req_valid held stable with owner's address; handshake completes on cycle ready rises.
- DC write with mem_req_data_ready delayed 3 cycles -> dc_req_data_ready mirrors it; state returns IDLE one cycle after beat accepted.
- mem_resp_valid pulse while IDLE -> no client resp_valid; err_stray_resp=1 until reset.
- reset asserted during RRESP after 2 beats -> all outputs 0 next cycle; later beats produce no resp_valid; new request arbitrates with DC priority.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the memory-port arbiter.
package mem_arbiter_pkg;

    localparam int unsigned MemDataBits = 128;

    // Client identifiers; also the encoding of the owner and last-grant registers.
    localparam logic ArbIc = 1'b0;
    localparam logic ArbDc = 1'b1;

    typedef enum logic [1:0] {
        ArbIdle,
        ArbReq,
        ArbWdata,
        ArbRresp
    } arb_state_e;

    // Smallest r such that 2**r >= v (0 for v <= 1).
    function automatic int unsigned ceil_log2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned p = 1; p < v; p = p << 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr2.sv
// Two-input round-robin picker; remembers the last granted client.
module arb_rr2
    import mem_arbiter_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req_ic,
    input  logic req_dc,
    input  logic grant_en,
    output logic grant_valid,
    output logic grant
);

    logic last_grant_q, last_grant_d;

    // Pick the requester; on a tie prefer the client that was not granted last.
    always_comb begin
        grant_valid = req_ic | req_dc;
        if (req_ic && req_dc) begin
            grant = ~last_grant_q;
        end else begin
            grant = req_dc ? ArbDc : ArbIc;
        end
        last_grant_d = (grant_en && grant_valid) ? grant : last_grant_q;
    end

    // Last-grant register; IC after reset so DC wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= ArbIc;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the I-cache and D-cache memory ports onto one main-memory port,
// one transaction at a time, and steers read beats back to the owner.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned MEM_DATA_BITS = MemDataBits,
    parameter int unsigned MEM_ADDR_BITS = 28,
    parameter int unsigned READ_BEATS    = 4,
    parameter int unsigned WRITE_BEATS   = 1
) (
    input  logic                       clk,
    input  logic                       reset,

    input  logic                       ic_req_valid,
    output logic                       ic_req_ready,
    input  logic [MEM_ADDR_BITS-1:0]   ic_req_addr,
    input  logic                       ic_req_rw,
    input  logic                       ic_req_data_valid,
    output logic                       ic_req_data_ready,
    input  logic [MEM_DATA_BITS-1:0]   ic_req_data_bits,
    input  logic [MEM_DATA_BITS/8-1:0] ic_req_data_mask,
    output logic                       ic_resp_valid,
    output logic [MEM_DATA_BITS-1:0]   ic_resp_data,

    input  logic                       dc_req_valid,
    output logic                       dc_req_ready,
    input  logic [MEM_ADDR_BITS-1:0]   dc_req_addr,
    input  logic                       dc_req_rw,
    input  logic                       dc_req_data_valid,
    output logic                       dc_req_data_ready,
    input  logic [MEM_DATA_BITS-1:0]   dc_req_data_bits,
    input  logic [MEM_DATA_BITS/8-1:0] dc_req_data_mask,
    output logic                       dc_resp_valid,
    output logic [MEM_DATA_BITS-1:0]   dc_resp_data,

    output logic                       mem_req_valid,
    input  logic                       mem_req_ready,
    output logic [MEM_ADDR_BITS-1:0]   mem_req_addr,
    output logic                       mem_req_rw,
    output logic                       mem_req_data_valid,
    input  logic                       mem_req_data_ready,
    output logic [MEM_DATA_BITS-1:0]   mem_req_data_bits,
    output logic [MEM_DATA_BITS/8-1:0] mem_req_data_mask,
    input  logic                       mem_resp_valid,
    input  logic [MEM_DATA_BITS-1:0]   mem_resp_data,

    output logic                       err_stray_resp
);

    localparam int unsigned MaxBeats = (READ_BEATS > WRITE_BEATS) ? READ_BEATS : WRITE_BEATS;
    localparam int unsigned CntW     = ceil_log2(MaxBeats) + 1;

    arb_state_e      state_q, state_d;
    // Owner is only meaningful outside ArbIdle; ArbIdle stands for "no owner".
    logic            owner_q, owner_d;
    logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
    logic            err_q, err_d;

    logic            grant_valid, grant;
    logic            own_req_valid, own_req_rw, own_data_valid;

    arb_rr2 u_rr2 (
        .clk        (clk),
        .reset      (reset),
        .req_ic     (ic_req_valid),
        .req_dc     (dc_req_valid),
        .grant_en   (state_q == ArbIdle),
        .grant_valid(grant_valid),
        .grant      (grant)
    );

    // Owner's request signals and the memory-side payload muxes.
    always_comb begin
        own_req_valid     = (owner_q == ArbDc) ? dc_req_valid      : ic_req_valid;
        own_req_rw        = (owner_q == ArbDc) ? dc_req_rw         : ic_req_rw;
        own_data_valid    = (owner_q == ArbDc) ? dc_req_data_valid : ic_req_data_valid;
        mem_req_addr      = (owner_q == ArbDc) ? dc_req_addr       : ic_req_addr;
        mem_req_rw        = own_req_rw;
        mem_req_data_bits = (owner_q == ArbDc) ? dc_req_data_bits  : ic_req_data_bits;
        mem_req_data_mask = (owner_q == ArbDc) ? dc_req_data_mask  : ic_req_data_mask;
        ic_resp_data      = mem_resp_data;
        dc_resp_data      = mem_resp_data;
        err_stray_resp    = err_q;
    end

    // Handshake steering per state; everything is held low while reset is high.
    always_comb begin
        mem_req_valid      = 1'b0;
        mem_req_data_valid = 1'b0;
        ic_req_ready       = 1'b0;
        dc_req_ready       = 1'b0;
        ic_req_data_ready  = 1'b0;
        dc_req_data_ready  = 1'b0;
        ic_resp_valid      = 1'b0;
        dc_resp_valid      = 1'b0;
        if (!reset) begin
            unique case (state_q)
                ArbReq: begin
                    mem_req_valid = own_req_valid;
                    ic_req_ready  = (owner_q == ArbIc) && mem_req_ready;
                    dc_req_ready  = (owner_q == ArbDc) && mem_req_ready;
                end
                ArbWdata: begin
                    mem_req_data_valid = own_data_valid;
                    ic_req_data_ready  = (owner_q == ArbIc) && mem_req_data_ready;
                    dc_req_data_ready  = (owner_q == ArbDc) && mem_req_data_ready;
                end
                ArbRresp: begin
                    ic_resp_valid = (owner_q == ArbIc) && mem_resp_valid;
                    dc_resp_valid = (owner_q == ArbDc) && mem_resp_valid;
                end
                default: ;
            endcase
        end
    end

    // Next-state: grant, address handshake, beat counting and stray-beat detection.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        cnt_inc = cnt_q + 1'b1;
        if (mem_resp_valid && (state_q != ArbRresp)) begin
            err_d = 1'b1;
        end
        unique case (state_q)
            ArbIdle: begin
                if (grant_valid) begin
                    owner_d = grant;
                    state_d = ArbReq;
                end
            end
            ArbReq: begin
                if (!own_req_valid) begin
                    state_d = ArbIdle;
                end else if (mem_req_ready) begin
                    state_d = own_req_rw ? ArbWdata : ArbRresp;
                    cnt_d   = '0;
                end
            end
            ArbWdata: begin
                if (own_data_valid && mem_req_data_ready) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CntW'(WRITE_BEATS)) begin
                        state_d = ArbIdle;
                    end
                end
            end
            ArbRresp: begin
                if (mem_resp_valid) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CntW'(READ_BEATS)) begin
                        state_d = ArbIdle;
                    end
                end
            end
            default: state_d = ArbIdle;
        endcase
    end

    // State, owner, beat counter and sticky error registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ArbIdle;
            owner_q <= ArbIc;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised scoreboard bench for mem_arbiter with a transaction-level model.
module tb_mem_arbiter;

    localparam int DW = 128;
    localparam int AW = 28;
    localparam int MW = 16;
    localparam int RB = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          ic_req_valid, ic_req_ready, ic_req_rw, ic_req_data_valid, ic_req_data_ready;
    logic [AW-1:0] ic_req_addr;
    logic [DW-1:0] ic_req_data_bits, ic_resp_data;
    logic [MW-1:0] ic_req_data_mask;
    logic          ic_resp_valid;
    logic          dc_req_valid, dc_req_ready, dc_req_rw, dc_req_data_valid, dc_req_data_ready;
    logic [AW-1:0] dc_req_addr;
    logic [DW-1:0] dc_req_data_bits, dc_resp_data;
    logic [MW-1:0] dc_req_data_mask;
    logic          dc_resp_valid;
    logic          mem_req_valid, mem_req_ready, mem_req_rw, mem_req_data_valid;
    logic          mem_req_data_ready, mem_resp_valid, err_stray_resp;
    logic [AW-1:0] mem_req_addr;
    logic [DW-1:0] mem_req_data_bits, mem_resp_data;
    logic [MW-1:0] mem_req_data_mask;

    always #5 clk = ~clk;

    mem_arbiter #(
        .MEM_DATA_BITS(DW),
        .MEM_ADDR_BITS(AW),
        .READ_BEATS   (RB),
        .WRITE_BEATS  (1)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .ic_req_valid      (ic_req_valid),
        .ic_req_ready      (ic_req_ready),
        .ic_req_addr       (ic_req_addr),
        .ic_req_rw         (ic_req_rw),
        .ic_req_data_valid (ic_req_data_valid),
        .ic_req_data_ready (ic_req_data_ready),
        .ic_req_data_bits  (ic_req_data_bits),
        .ic_req_data_mask  (ic_req_data_mask),
        .ic_resp_valid     (ic_resp_valid),
        .ic_resp_data      (ic_resp_data),
        .dc_req_valid      (dc_req_valid),
        .dc_req_ready      (dc_req_ready),
        .dc_req_addr       (dc_req_addr),
        .dc_req_rw         (dc_req_rw),
        .dc_req_data_valid (dc_req_data_valid),
        .dc_req_data_ready (dc_req_data_ready),
        .dc_req_data_bits  (dc_req_data_bits),
        .dc_req_data_mask  (dc_req_data_mask),
        .dc_resp_valid     (dc_resp_valid),
        .dc_resp_data      (dc_resp_data),
        .mem_req_valid     (mem_req_valid),
        .mem_req_ready     (mem_req_ready),
        .mem_req_addr      (mem_req_addr),
        .mem_req_rw        (mem_req_rw),
        .mem_req_data_valid(mem_req_data_valid),
        .mem_req_data_ready(mem_req_data_ready),
        .mem_req_data_bits (mem_req_data_bits),
        .mem_req_data_mask (mem_req_data_mask),
        .mem_resp_valid    (mem_resp_valid),
        .mem_resp_data     (mem_resp_data),
        .err_stray_resp    (err_stray_resp)
    );

    typedef struct {
        logic          client;  // 0 = IC, 1 = DC
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [MW-1:0] mask;
    } txn_t;

    typedef struct {
        logic          client;
        logic [DW-1:0] data;
    } resp_t;

    txn_t  exp_mem[$];
    resp_t exp_resp[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    logic  model_last;

    // Monitor-side state, shared with the stimulus loop (written only by the monitor).
    txn_t  cur;
    resp_t mon_r;
    logic  wr_pend   = 1'b0;
    logic  rd_start  = 1'b0;
    logic  rd_client = 1'b0;
    logic  f_ic_req = 1'b0, f_dc_req = 1'b0, f_ic_dat = 1'b0, f_dc_dat = 1'b0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [DW-1:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [7:0] outs();
        return {mem_req_valid, mem_req_data_valid, ic_req_ready, dc_req_ready,
                ic_req_data_ready, dc_req_data_ready, ic_resp_valid, dc_resp_valid};
    endfunction

    // Monitor: samples mid-cycle and checks everything the DUT presents.
    always @(negedge clk) begin
        f_ic_req = ic_req_valid && ic_req_ready;
        f_dc_req = dc_req_valid && dc_req_ready;
        f_ic_dat = ic_req_data_valid && ic_req_data_ready;
        f_dc_dat = dc_req_data_valid && dc_req_data_ready;
        rd_start = 1'b0;
        if (reset) begin
            wr_pend = 1'b0;
        end else begin
            if (mem_req_valid) begin
                chk("mem_req_expected", DW'(exp_mem.size() != 0), DW'(1));
                if (exp_mem.size() != 0) begin
                    chk("mem_req_addr", DW'(mem_req_addr), DW'(exp_mem[0].addr));
                    chk("mem_req_rw", DW'(mem_req_rw), DW'(exp_mem[0].rw));
                    chk("owner_req_ready", DW'({ic_req_ready, dc_req_ready}),
                        exp_mem[0].client ? DW'({1'b0, mem_req_ready})
                                          : DW'({mem_req_ready, 1'b0}));
                    if (mem_req_ready) begin
                        cur = exp_mem.pop_front();
                        if (cur.rw) begin
                            wr_pend = 1'b1;
                        end else begin
                            rd_start  = 1'b1;
                            rd_client = cur.client;
                        end
                    end
                end
            end
            if (mem_req_data_valid) begin
                chk("data_phase_expected", DW'(wr_pend), DW'(1));
                chk("owner_data_ready", DW'({ic_req_data_ready, dc_req_data_ready}),
                    cur.client ? DW'({1'b0, mem_req_data_ready})
                               : DW'({mem_req_data_ready, 1'b0}));
                if (mem_req_data_ready) begin
                    chk("mem_data_bits", mem_req_data_bits, cur.data);
                    chk("mem_data_mask", DW'(mem_req_data_mask), DW'(cur.mask));
                    wr_pend = 1'b0;
                end
            end
            if (ic_resp_valid || dc_resp_valid) begin
                chk("resp_one_hot", DW'(ic_resp_valid && dc_resp_valid), DW'(0));
                chk("resp_expected", DW'(exp_resp.size() != 0), DW'(1));
                if (exp_resp.size() != 0) begin
                    mon_r = exp_resp.pop_front();
                    chk("resp_client", DW'(dc_resp_valid), DW'(mon_r.client));
                    chk("resp_data", dc_resp_valid ? dc_resp_data : ic_resp_data, mon_r.data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One arbitration round: pat bit0 = IC requests, bit1 = DC requests, same cycle.
    task automatic run_round(input int pat);
        txn_t t[2];
        logic first, w, done;
        logic ic_got, dc_got, ic_wd, dc_wd;
        int   rd_left;
        for (int c = 0; c < 2; c++) begin
            t[c] = '{c[0], 1'($urandom_range(0, 1)), AW'($urandom), rand128(), MW'($urandom)};
        end
        // Reference: single requester wins; on a tie the client not granted last goes first.
        if (pat == 3) begin
            first = ~model_last;
            exp_mem.push_back(t[first]);
            exp_mem.push_back(t[~first]);
            model_last = ~first;
        end else begin
            w = (pat == 2);
            exp_mem.push_back(t[w]);
            model_last = w;
        end
        if (pat[0]) begin
            ic_req_valid = 1'b1; ic_req_addr = t[0].addr; ic_req_rw = t[0].rw;
            ic_req_data_valid = t[0].rw; ic_req_data_bits = t[0].data;
            ic_req_data_mask = t[0].mask;
        end
        if (pat[1]) begin
            dc_req_valid = 1'b1; dc_req_addr = t[1].addr; dc_req_rw = t[1].rw;
            dc_req_data_valid = t[1].rw; dc_req_data_bits = t[1].data;
            dc_req_data_mask = t[1].mask;
        end
        ic_got = 1'b0; dc_got = 1'b0; ic_wd = 1'b0; dc_wd = 1'b0;
        rd_left = 0;
        done = 1'b0;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            step();
            if (rd_start) rd_left = RB;
            if (f_ic_req) begin ic_req_valid = 1'b0; ic_got = 1'b1; end
            if (f_dc_req) begin dc_req_valid = 1'b0; dc_got = 1'b1; end
            if (f_ic_dat) begin ic_req_data_valid = 1'b0; ic_wd = 1'b1; end
            if (f_dc_dat) begin dc_req_data_valid = 1'b0; dc_wd = 1'b1; end
            mem_req_ready      = ($urandom_range(0, 2) == 0);
            mem_req_data_ready = ($urandom_range(0, 1) == 0);
            if (rd_left > 0 && $urandom_range(0, 3) != 0) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = rand128();
                exp_resp.push_back('{rd_client, mem_resp_data});
                rd_left--;
            end else begin
                mem_resp_valid = 1'b0;
            end
            done = (!pat[0] || (ic_got && (!t[0].rw || ic_wd))) &&
                   (!pat[1] || (dc_got && (!t[1].rw || dc_wd))) &&
                   (rd_left == 0) && !mem_resp_valid;
        end
        chk("round_complete", DW'(done), DW'(1));
        step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mem_resp_valid = 1'b0;
        step();
        step();
        reset = 1'b0;
        model_last = 1'b0;
        exp_mem.delete();
        exp_resp.delete();
        #1;
    endtask

    initial begin
        reset = 1'b1;
        {ic_req_valid, ic_req_rw, ic_req_data_valid} = '0;
        {dc_req_valid, dc_req_rw, dc_req_data_valid} = '0;
        ic_req_addr = '0; ic_req_data_bits = '0; ic_req_data_mask = '0;
        dc_req_addr = '0; dc_req_data_bits = '0; dc_req_data_mask = '0;
        mem_req_ready = 1'b0; mem_req_data_ready = 1'b0;
        mem_resp_valid = 1'b0; mem_resp_data = '0;
        model_last = 1'b0;
        step();
        step();
        chk("outs_during_reset", DW'(outs()), DW'(0));
        reset = 1'b0;
        #1;
        chk("outs_after_reset", DW'(outs()), DW'(0));
        chk("err_after_reset", DW'(err_stray_resp), DW'(0));

        // First tie after reset must go to DC; then random mixes.
        run_round(3);
        for (int i = 0; i < 40; i++) begin
            run_round(int'($urandom_range(1, 3)));
        end
        chk("err_clean_after_traffic", DW'(err_stray_resp), DW'(0));

        // Stray response while idle: no client sees it, error is sticky until reset.
        mem_resp_valid = 1'b1;
        mem_resp_data  = rand128();
        step();
        mem_resp_valid = 1'b0;
        chk("err_stray_set", DW'(err_stray_resp), DW'(1));
        step(); step(); step();
        chk("err_stray_sticky", DW'(err_stray_resp), DW'(1));
        do_reset();
        chk("err_cleared_by_reset", DW'(err_stray_resp), DW'(0));

        // IC read at 0x10: one-cycle latency, then reset after two beats.
        mem_req_ready = 1'b1;
        ic_req_valid = 1'b1; ic_req_addr = AW'(28'h0000010); ic_req_rw = 1'b0;
        ic_req_data_valid = 1'b0;
        exp_mem.push_back('{1'b0, 1'b0, AW'(28'h0000010), DW'(0), MW'(0)});
        model_last = 1'b0;
        step();
        chk("latency_mem_req_valid", DW'(mem_req_valid), DW'(1));
        chk("latency_mem_req_addr", DW'(mem_req_addr), DW'(28'h0000010));
        step();
        ic_req_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = rand128();
            exp_resp.push_back('{1'b0, mem_resp_data});
            step();
        end
        mem_resp_valid = 1'b1;
        mem_resp_data  = rand128();
        reset = 1'b1;
        #1;
        chk("outs_low_in_reset", DW'(outs()), DW'(0));
        step();
        reset = 1'b0;
        model_last = 1'b0;
        #1;
        chk("outs_low_after_abort", DW'(outs()), DW'(0));
        step();
        step();
        mem_resp_valid = 1'b0;
        chk("err_after_aborted_beats", DW'(err_stray_resp), DW'(1));
        chk("resp_queue_drained", DW'(exp_resp.size()), DW'(0));
        run_round(3);
        run_round(3);

        chk("exp_mem_drained", DW'(exp_mem.size()), DW'(0));
        chk("exp_resp_drained", DW'(exp_resp.size()), DW'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
